// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and types for the data-RAM port arbiter.
// Holds the default starvation limit, the starvation counter width and the
// default statistics counter width used by the pipeline top and host loader.
package dmem_port_arbiter_pkg;

  localparam int unsigned DefHostWaitMax = 8;
  localparam int unsigned WaitW          = 8;
  localparam int unsigned DefCntW        = 16;

  // Which side owns the RAM port in the current cycle.
  typedef enum logic {
    OWNER_PIPE = 1'b0,
    OWNER_HOST = 1'b1
  } ram_owner_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter between the MEM stage and a host port.
// The pipeline normally wins; a host request refused HOST_WAIT_MAX cycles in a
// row is forced through and the pipeline is stalled for that one cycle.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned HOST_WAIT_MAX = DefHostWaitMax,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  forced_cnt
);

  localparam logic [WaitW-1:0] WaitMax = WaitW'(HOST_WAIT_MAX);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [CNT_W-1:0]  forced_cnt_q, forced_cnt_d;
  logic              force_grant;
  ram_owner_e        owner;

  // Decide who owns the RAM this cycle: host when the pipe is idle or the host has starved long enough.
  always_comb begin
    force_grant = host_req & (wait_cnt_q == WaitMax);
    host_gnt    = host_req & (~pipe_req | force_grant);
    pipe_stall  = pipe_req & host_gnt;
    owner       = host_gnt ? OWNER_HOST : OWNER_PIPE;
  end

  // Steer the granted side onto the RAM port; a pipe write only counts when the pipe really accesses memory.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = pipe_addr;
    ram_wdata = pipe_wdata;
    case (owner)
      OWNER_HOST: begin
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
      end
      default: begin
        ram_we    = pipe_we & pipe_req;
        ram_addr  = pipe_addr;
        ram_wdata = pipe_wdata;
      end
    endcase
  end

  // Next-state: starvation counter, host read return and saturating forced-grant statistic.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    forced_cnt_d  = forced_cnt_q;

    if (~host_req | host_gnt) begin
      wait_cnt_d = '0;
    end else if (pipe_req & ~force_grant) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (host_gnt & ~host_we) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = ram_rdata;
    end

    if (force_grant & pipe_req & (forced_cnt_q != CntMax)) begin
      forced_cnt_d = forced_cnt_q + 1'b1;
    end
  end

  // State registers; an asynchronous reset drops a pending read return immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      forced_cnt_q  <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      forced_cnt_q  <= forced_cnt_d;
    end
  end

  assign pipe_rdata  = ram_rdata;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign forced_cnt  = forced_cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter.
// A small RAM sits on the ram_* port; a reference model works from the
// arbitration rules (refusal streak, grant owner, shadow memory) and is
// compared every cycle, alongside directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

  localparam int WAIT_MAX   = 8;
  localparam int TB_CNT_W   = 4;
  localparam int FORCED_MAX = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                clrn;
  logic                pipeReq, pipeWe;
  logic [31:0]         pipeAddr, pipeWdata, pipeRdata;
  logic                pipeStall;
  logic                hostReq, hostWe;
  logic [31:0]         hostAddr, hostWdata;
  logic                hostGnt, hostRvalid;
  logic [31:0]         hostRdata;
  logic                ramWe;
  logic [31:0]         ramAddr, ramWdata, ramRdata;
  logic [TB_CNT_W-1:0] forcedCnt;

  int compared;
  int mismatched;

  // reference model state
  int          mRefused;
  logic        mRvalid;
  logic [31:0] mRdata;
  int          mForced;
  logic [31:0] modelMem [0:63];

  logic [31:0] ramMem [0:63];

  dmem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .HOST_WAIT_MAX(WAIT_MAX),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .pipe_req(pipeReq),
    .pipe_we(pipeWe),
    .pipe_addr(pipeAddr),
    .pipe_wdata(pipeWdata),
    .pipe_rdata(pipeRdata),
    .pipe_stall(pipeStall),
    .host_req(hostReq),
    .host_we(hostWe),
    .host_addr(hostAddr),
    .host_wdata(hostWdata),
    .host_gnt(hostGnt),
    .host_rvalid(hostRvalid),
    .host_rdata(hostRdata),
    .ram_we(ramWe),
    .ram_addr(ramAddr),
    .ram_wdata(ramWdata),
    .ram_rdata(ramRdata),
    .forced_cnt(forcedCnt)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // single-port RAM with combinational read and write on the rising edge
  assign ramRdata = ramMem[ramAddr[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) ramMem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (ramWe) ramMem[ramAddr[7:2]] <= ramWdata;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // compare the DUT against the model for the current cycle, then advance the model
  task automatic compareCycle();
    logic        forcedNow, gnt, stall, expWe;
    logic [31:0] expAddr, expWdata;
    if (!clrn) begin
      mRefused = 0;
      mRvalid  = 1'b0;
      mRdata   = 32'h0;
      mForced  = 0;
    end
    forcedNow = hostReq && (mRefused == WAIT_MAX);
    gnt       = hostReq && (!pipeReq || forcedNow);
    stall     = pipeReq && gnt;
    expWe     = gnt ? hostWe : (pipeReq && pipeWe);
    expAddr   = gnt ? hostAddr : pipeAddr;
    expWdata  = gnt ? hostWdata : pipeWdata;

    checkOutput("host_gnt", hostGnt, gnt);
    checkOutput("pipe_stall", pipeStall, stall);
    checkOutput("ram_we", ramWe, expWe);
    checkOutput("ram_addr", ramAddr, expAddr);
    checkOutput("ram_wdata", ramWdata, expWdata);
    checkOutput("host_rvalid", hostRvalid, mRvalid);
    checkOutput("host_rdata", hostRdata, mRdata);
    checkOutput("forced_cnt", forcedCnt, mForced);
    if (pipeReq && !pipeWe && !stall)
      checkOutput("pipe_rdata", pipeRdata, modelMem[pipeAddr[7:2]]);

    if (clrn) begin
      if (gnt && !hostWe) begin
        mRvalid = 1'b1;
        mRdata  = modelMem[hostAddr[7:2]];
      end else begin
        mRvalid = 1'b0;
      end
      if (forcedNow && pipeReq && mForced < FORCED_MAX) mForced++;
      mRefused = (hostReq && !gnt) ? mRefused + 1 : 0;
    end
    if (expWe) modelMem[expAddr[7:2]] = expWdata;
  endtask

  // drive one cycle of inputs after the rising edge, then check at the falling edge
  task automatic applyStimulus(input logic nRst,
                               input logic pReq, input logic pWe, input logic [31:0] pAddr, input logic [31:0] pWdata,
                               input logic hReq, input logic hWe, input logic [31:0] hAddr, input logic [31:0] hWdata);
    @(posedge clk);
    #1;
    clrn      = nRst;
    pipeReq   = pReq;
    pipeWe    = pWe;
    pipeAddr  = pAddr;
    pipeWdata = pWdata;
    hostReq   = hReq;
    hostWe    = hWe;
    hostAddr  = hAddr;
    hostWdata = hWdata;
    @(negedge clk);
    compareCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] randAddr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  // directed scenarios followed by constrained-random traffic
  initial begin
    logic        pR, pW, hR, hW, lastGnt, nRst;
    logic [31:0] pA, pD, hA, hD;

    compared   = 0;
    mismatched = 0;
    mRefused   = 0;
    mRvalid    = 1'b0;
    mRdata     = 32'h0;
    mForced    = 0;
    for (int i = 0; i < 64; i++) modelMem[i] = 32'h0;
    clrn = 1'b0; pipeReq = 1'b0; pipeWe = 1'b0; pipeAddr = 32'h0; pipeWdata = 32'h0;
    hostReq = 1'b0; hostWe = 1'b0; hostAddr = 32'h0; hostWdata = 32'h0;

    // reset with every request asserted
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("rst_rvalid", hostRvalid, 1'b0);
    checkOutput("rst_forced", forcedCnt, 0);
    checkOutput("rst_gnt", hostGnt, 1'b0);
    checkOutput("rst_stall", pipeStall, 1'b0);
    idleCycle();

    // host write then read with an idle pipe
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    checkOutput("idle_wr_gnt", hostGnt, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("idle_rd_gnt", hostGnt, 1'b1);
    idleCycle();
    checkOutput("idle_rvalid", hostRvalid, 1'b1);
    checkOutput("idle_rdata", hostRdata, 32'hDEADBEEF);

    // starvation: grants at t0+8 and t0+17
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("starve_gnt", hostGnt, (k == 8 || k == 17));
      checkOutput("starve_stall", pipeStall, (k == 8 || k == 17));
      if (k == 9 || k == 17) checkOutput("starve_forced", forcedCnt, 1);
    end

    // keep starving until the statistics counter saturates
    for (int k = 0; k < 150; k++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    checkOutput("sat_forced", forcedCnt, FORCED_MAX);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    checkOutput("sat_nowrap", forcedCnt, FORCED_MAX);

    // coherence between forced host write and pipeline load, and pipeline store and host read
    idleCycle();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h5);
      checkOutput("coh_wr_gnt", hostGnt, (k == 8));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("coh_pipe_rdata", pipeRdata, 32'h5);
    checkOutput("coh_pipe_stall", pipeStall, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("coh_rd_gnt", hostGnt, 1'b1);
    idleCycle();
    checkOutput("coh_rvalid", hostRvalid, 1'b1);
    checkOutput("coh_host_rdata", hostRdata, 32'h7);

    // host drops its request: the refusal streak restarts
    idleCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("drop_pre_gnt", hostGnt, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      checkOutput("drop_post_gnt", hostGnt, (k == 8));
    end

    // reset between a granted read and its return edge
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("rstrd_gnt", hostGnt, 1'b1);
    #2;
    clrn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rstrd_rvalid", hostRvalid, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("rstrd_regnt", hostGnt, 1'b1);
    idleCycle();
    checkOutput("rstrd_rvalid2", hostRvalid, 1'b1);
    checkOutput("rstrd_rdata", hostRdata, 32'hDEADBEEF);

    // random traffic; the host holds its request until granted, occasionally giving up
    hR = 1'b0; hW = 1'b0; hA = 32'h0; hD = 32'h0; lastGnt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      pR = ($urandom_range(0, 9) < 7);
      pW = $urandom_range(0, 1) == 1;
      pA = randAddr();
      pD = $urandom;
      if (hR && !lastGnt) begin
        if ($urandom_range(0, 19) == 0) hR = 1'b0;
      end else begin
        hR = $urandom_range(0, 2) != 0;
        hW = $urandom_range(0, 1) == 1;
        hA = randAddr();
        hD = $urandom;
      end
      nRst = $urandom_range(0, 399) != 0;
      applyStimulus(nRst, pR, pW, pA, pD, hR, hW, hA, hD);
      lastGnt = hostGnt;
    end
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
